// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with one-entry skid and redirect handling
// Keeps a request stable until acked; a redirect raised mid-request is parked until that ack.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_SKID = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        transfer;
  logic        accept;
  logic        consumed;
  logic [31:0] redir_target;

  // Reset gates the request combinationally so a pending access is abandoned at once.
  assign imem_req_o   = !RESET && (state == ST_REQ || state == ST_DROP);
  assign imem_addr_o  = pc_q;
  assign transfer     = imem_req_o && imem_ack_i;
  assign accept       = !instr_valid_o || !stall_i;
  assign consumed     = instr_valid_o && !stall_i;
  assign redir_target = redirect_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_REQ;
      pc_q          <= RESET_PC & 32'hFFFF_FFFC;
      redir_q       <= 32'h0;
      skid_valid    <= 1'b0;
      skid_instr    <= NOP_INSTR;
      skid_pc       <= 32'h0;
      instr_valid_o <= 1'b0;
      instr_o       <= NOP_INSTR;
      pc_o          <= 32'h0;
    end else begin
      if (consumed) begin
        instr_valid_o <= 1'b0;
        instr_o       <= NOP_INSTR;
      end

      case (state)
        ST_REQ: begin
          if (redirect_i) begin
            if (transfer) begin
              pc_q <= redir_target;
            end else begin
              redir_q <= redir_target;
              state   <= ST_DROP;
            end
          end else if (transfer) begin
            pc_q <= pc_q + 32'd4;
            if (accept) begin
              instr_valid_o <= 1'b1;
              instr_o       <= imem_rdata_i;
              pc_o          <= pc_q;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata_i;
              skid_pc    <= pc_q;
              state      <= ST_SKID;
            end
          end
        end

        ST_SKID: begin
          if (redirect_i) begin
            skid_valid <= 1'b0;
            pc_q       <= redir_target;
            state      <= ST_REQ;
          end else if (accept) begin
            instr_valid_o <= skid_valid;
            instr_o       <= skid_instr;
            pc_o          <= skid_pc;
            skid_valid    <= 1'b0;
            state         <= ST_REQ;
          end
        end

        ST_DROP: begin
          // The stale request must complete; its data is discarded.
          if (transfer) begin
            pc_q  <= redirect_i ? redir_target : redir_q;
            state <= ST_REQ;
          end
          if (redirect_i) begin
            redir_q <= redir_target;
          end
        end

        default: begin
          state <= ST_REQ;
        end
      endcase

      if (redirect_i) begin
        instr_valid_o <= 1'b0;
        instr_o       <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with fetch-stream scoreboard
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int checks = 0;
  int failures = 0;

  fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .CLK(CLK), .RESET(RESET), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A13;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  // Scoreboard: expected {instr, pc} pushed on kept transfers, popped on consumption.
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] pend_addr = 32'h0;
  logic        dropping = 1'b0;

  always @(negedge CLK) begin
    logic [63:0] front;
    logic [31:0] tgt;
    logic        xfer;
    if (RESET) begin
      sb_q.delete();
      exp_addr = RESET_PC;
      dropping = 1'b0;
    end else begin
      if (imem_req_o) begin
        checks++;
        if (imem_addr_o !== exp_addr) begin
          failures++;
          $display("FAIL sb_addr: got %h expected %h at %0t", imem_addr_o, exp_addr, $time);
        end
      end
      if (instr_valid_o && !stall_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got pc %h instr %h expected none at %0t", pc_o, instr_o, $time);
        end else begin
          front = sb_q.pop_front();
          if ({instr_o, pc_o} !== front) begin
            failures++;
            $display("FAIL sb_data: got instr %h pc %h expected instr %h pc %h", instr_o, pc_o,
                     front[63:32], front[31:0]);
          end
        end
      end
      xfer = imem_req_o && imem_ack_i;
      tgt  = {redirect_pc_i[31:2], 2'b00};
      if (redirect_i) begin
        sb_q.delete();
        if (xfer || !imem_req_o) begin
          exp_addr = tgt;
          dropping = 1'b0;
        end else begin
          dropping  = 1'b1;
          pend_addr = tgt;
        end
      end else if (xfer) begin
        if (dropping) begin
          exp_addr = pend_addr;
          dropping = 1'b0;
        end else begin
          sb_q.push_back({mem_word(exp_addr), exp_addr});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain_and_check(input string name);
    imem_ack_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    repeat (4) cyc();
    checks++;
    if (sb_q.size() != 0 || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending valid=%b expected 0 pending valid=0", name, sb_q.size(), instr_valid_o);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; imem_ack_i = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: got %b expected 0", imem_req_o);
    end
    cyc();
    checks++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP_INSTR || pc_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b i=%h pc=%h expected v=0 i=%h pc=0", instr_valid_o, instr_o, pc_o, NOP_INSTR);
    end
  endtask

  task automatic test_stream();
    RESET = 1'b1; imem_ack_i = 1'b0;
    cyc();
    RESET = 1'b0; imem_ack_i = 1'b1; stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i)) begin
        failures++;
        $display("FAIL stream_addr%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req_o, imem_addr_o, 32'(4 * i));
      end
      checks++;
      if (i == 0 ? (instr_valid_o !== 1'b0) : (instr_valid_o !== 1'b1 || pc_o !== 32'(4 * (i - 1)))) begin
        failures++;
        $display("FAIL stream_out%0d: got v=%b pc=%h", i, instr_valid_o, pc_o);
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    stall_i = 1'b1; imem_ack_i = 1'b1;
    @(negedge CLK);
    held_pc = pc_o; held_instr = instr_o;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge CLK);
        checks++;
        if (imem_req_o !== 1'b0) begin
          failures++;
          $display("FAIL stall_req%0d: got %b expected 0", i, imem_req_o);
        end
      end
      checks++;
      if (instr_valid_o !== 1'b1 || pc_o !== held_pc || instr_o !== held_instr) begin
        failures++;
        $display("FAIL stall_hold%0d: got v=%b pc=%h expected v=1 pc=%h", i, instr_valid_o, pc_o, held_pc);
      end
      cyc();
    end
    stall_i = 1'b0;
    repeat (4) cyc();
    drain_and_check("stall");
  endtask

  task automatic test_redirect_pending();
    RESET = 1'b1;
    cyc();
    RESET = 1'b0; imem_ack_i = 1'b1;
    cyc();
    cyc();
    imem_ack_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cyc();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      imem_ack_i = (i == 1);
      @(negedge CLK);
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || instr_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL redir_hold%0d: got req=%b addr=%h v=%b expected req=1 addr=8 v=0", i, imem_req_o, imem_addr_o, instr_valid_o);
      end
      cyc();
    end
    imem_ack_i = 1'b1;
    @(negedge CLK);
    checks++;
    if (imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL redir_target: got addr=%h v=%b expected addr=100 v=0", imem_addr_o, instr_valid_o);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin
      failures++;
      $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=100", instr_valid_o, pc_o, instr_o);
    end
    cyc();
  endtask

  task automatic test_redirect_stall();
    imem_ack_i = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h102;
    @(negedge CLK);
    checks++;
    if (instr_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL rstall_pre: got v=%b expected 1", instr_valid_o);
    end
    cyc();
    redirect_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (instr_valid_o !== 1'b0 || imem_addr_o !== 32'h100 || instr_o !== NOP_INSTR) begin
      failures++;
      $display("FAIL rstall_post: got v=%b addr=%h instr=%h expected v=0 addr=100 nop", instr_valid_o, imem_addr_o, instr_o);
    end
    cyc();
    imem_ack_i = 1'b1;
    repeat (3) cyc();
    drain_and_check("rstall");
  endtask

  task automatic test_reset_mid();
    imem_ack_i = 1'b1; stall_i = 1'b0;
    repeat (2) cyc();
    stall_i = 1'b1;
    cyc();
    RESET = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_skid_req: got %b expected 0", imem_req_o);
    end
    cyc();
    RESET = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_skid_after: got req=%b addr=%h v=%b expected req=1 addr=%h v=0", imem_req_o, imem_addr_o, instr_valid_o, RESET_PC);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    cyc();
    redirect_i = 1'b0; RESET = 1'b1;
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_drop_req: got %b expected 0", imem_req_o);
    end
    cyc();
    RESET = 1'b0; imem_ack_i = 1'b1;
    @(negedge CLK);
    checks++;
    if (imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rmid_drop_after: got addr=%h v=%b expected addr=%h v=0", imem_addr_o, instr_valid_o, RESET_PC);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    redirect_i = 1'b0;
    @(negedge CLK);
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_pre: got %h expected fffffffc", imem_addr_o);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if (imem_addr_o !== 32'h0 || instr_valid_o !== 1'b1 || pc_o !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_post: got addr=%h v=%b pc=%h expected addr=0 v=1 pc=fffffffc", imem_addr_o, instr_valid_o, pc_o);
    end
    cyc();
    drain_and_check("wrap");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset (bits [1:0] SHALL be 0).
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instr_o value while no valid instruction is held.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 stall_i  in  1  HazardDetect back-pressure: decode does not consume instr_o this cycle.
REQ-006 redirect_i  in  1  taken branch/jump from EX; flush and refetch.
REQ-007 redirect_pc_i  in  32  redirect target.
REQ-008 imem_req_o  out  1  instruction-memory request valid.
REQ-009 imem_addr_o  out  32  request address, word aligned.
REQ-010 imem_ack_i  in  1  memory accepts request and returns data this cycle; transfer = req & ack.
REQ-011 imem_rdata_i  in  32  instruction word, valid when transfer occurs.
REQ-012 instr_valid_o  out  1  instr_o/pc_o hold a valid fetched instruction.
REQ-013 instr_o  out  32  fetched instruction (registered).
REQ-014 pc_o  out  32  address of instr_o (registered).

Function
REQ-015 Internal state: fetch PC pc_q, redirect target redir_q, one-entry skid (instr, pc), output register, FSM {REQ, SKID, DROP}.
REQ-016 accept = !instr_valid_o | !stall_i; output register is consumed when instr_valid_o & !stall_i.
REQ-017 While imem_req_o=1 without ack, imem_addr_o SHALL stay stable; imem_req_o SHALL NOT drop before ack except by RESET.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc_q.
REQ-019 REQ, transfer, no redirect, accept=1: load output register with {imem_rdata_i, pc_q}, pc_q<=pc_q+4, stay REQ.
REQ-020 REQ, transfer, no redirect, accept=0: load skid with {imem_rdata_i, pc_q}, pc_q<=pc_q+4, go SKID.
REQ-021 SKID: imem_req_o=0; when accept=1, move skid to output register, go REQ.
REQ-022 REQ, redirect_i with transfer: discard returned data, pc_q<=redirect_pc_i, stay REQ.
REQ-023 REQ, redirect_i without transfer: redir_q<=redirect_pc_i, go DROP.
REQ-024 DROP: imem_req_o=1, imem_addr_o=pc_q (stale); on transfer discard data, pc_q<=redir_q, go REQ; a new redirect_i in DROP overwrites redir_q.
REQ-025 SKID, redirect_i: invalidate skid, pc_q<=redirect_pc_i, go REQ.
REQ-026 Any redirect_i: instr_valid_o<=0 next cycle; redirect has priority over stall_i and over any load.
REQ-027 Output register with no load and consumed: instr_valid_o<=0, instr_o<=NOP_INSTR; not consumed: hold all three outputs.
REQ-028 Latency: transfer in cycle n -> instr_valid_o=1 in cycle n+1; with ack=1, stall=0 throughput is one instruction per cycle.
REQ-029 redirect_pc_i[1:0] ignored (forced 00); pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

Reset
REQ-030 With RESET=1: imem_req_o=0 combinationally; next edge: pc_q=RESET_PC, FSM=REQ, skid invalid, instr_valid_o=0, instr_o=NOP_INSTR, pc_o=0, redir_q=0.
REQ-031 RESET mid-transaction abandons any outstanding request and drops skid/output contents; first request after release is RESET_PC.

Verification
REQ-032 Reset release, ack=1, stall=0 -> addrs 0,4,8 on consecutive cycles; instr_valid_o=1 from cycle after first ack, pc_o=0,4,8.
REQ-033 stall_i=1 for 3 cycles with ack=1 -> instr_o/pc_o held, one extra word in skid, req=0 in SKID; no loss/duplicate after stall release.
REQ-034 redirect_i=1, redirect_pc_i=0x100 while req at 0x8 unacked -> addr stays 0x8 until ack, data dropped, next addr 0x100, instr_valid_o=0 meanwhile.
REQ-035 redirect_i with stall_i=1 and valid output -> instr_valid_o=0 next cycle, next fetch 0x100 (redirect_pc_i=0x102 also fetches 0x100).
REQ-036 RESET=1 during DROP/SKID -> req=0, instr_valid_o=0; after release first address RESET_PC; pc_q=0xFFFFFFFC ack -> next address 0.
